// File: rtl/axi4_globals_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_globals_pkg
//  Description : Shared AXI4 BFM globals. Holds the outstanding-transaction
//                entry record and the default outstanding-store sizing.
//  Revision    : 1.0 - initial outstanding-id tracker support
// ============================================================================
package axi4_globals_pkg;

    // Field widths of a stored address-phase record.
    localparam int AXI4_ID_WIDTH          = 4;
    localparam int AXI4_ADDR_WIDTH        = 32;

    // Default total outstanding entries and per-id cap.
    localparam int OUTSTANDING_FIFO_DEPTH = 16;
    localparam int OST_MAX_PER_ID         = 16;

    // One outstanding address-phase record.
    typedef struct packed {
        logic [AXI4_ID_WIDTH-1:0]   id;
        logic [AXI4_ADDR_WIDTH-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } axi4_ost_entry_s;

endpackage : axi4_globals_pkg
`default_nettype wire

// File: rtl/axi4_outstanding_id_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_outstanding_id_tracker_if
//  Description : Bus bundle for the outstanding-id tracker.
//                push_* : address-phase record offer / accept
//                pop_*  : retire request by response id
//                rsp_*  : one-cycle-late retire result
//                count/empty/full/almost_full/id_busy : occupancy status
//                master modport drives push/pop, slave modport is the tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4_outstanding_id_tracker_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic                  push_valid;
    logic                  push_ready;
    logic [ID_WIDTH-1:0]   push_id;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [7:0]            push_len;
    logic [2:0]            push_size;
    logic [1:0]            push_burst;

    logic                  pop_req;
    logic [ID_WIDTH-1:0]   pop_id;

    logic                  rsp_valid;
    logic                  rsp_hit;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [7:0]            rsp_len;
    logic [2:0]            rsp_size;
    logic [1:0]            rsp_burst;

    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [NUM_IDS-1:0]    id_busy;

    modport master (
        output push_valid, push_id, push_addr, push_len, push_size, push_burst,
        output pop_req, pop_id,
        input  push_ready,
        input  rsp_valid, rsp_hit, rsp_addr, rsp_len, rsp_size, rsp_burst,
        input  count, empty, full, almost_full, id_busy
    );

    modport slave (
        input  push_valid, push_id, push_addr, push_len, push_size, push_burst,
        input  pop_req, pop_id,
        output push_ready,
        output rsp_valid, rsp_hit, rsp_addr, rsp_len, rsp_size, rsp_burst,
        output count, empty, full, almost_full, id_busy
    );

endinterface : axi4_outstanding_id_tracker_if
`default_nettype wire

// File: rtl/axi4_ost_first_match.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_ost_first_match
//  Description : Find-first-set over a match vector; lowest index wins.
//                match_i : DEPTH-wide match flags
//                hit_o   : any flag set
//                idx_o   : lowest set index (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_ost_first_match #(
    parameter int DEPTH = 16
) (
    input  wire logic [DEPTH-1:0]         match_i,
    output logic                          hit_o,
    output logic [$clog2(DEPTH)-1:0]      idx_o
);
    localparam int IDX_W = $clog2(DEPTH);

    always_comb begin
        hit_o = |match_i;
        idx_o = '0;
        // Scan from the top so the lowest matching index is written last.
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (match_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule : axi4_ost_first_match
`default_nettype wire

// File: rtl/axi4_outstanding_id_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_outstanding_id_tracker
//  Description : Outstanding AXI4 transaction store. Records address-phase
//                attributes on push; on pop retires the oldest entry with the
//                matching id (in-order per id, out-of-order across ids).
//                aclk/areset : clock, async active-high reset
//                bus         : slave side of axi4_outstanding_id_tracker_if
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_outstanding_id_tracker
    import axi4_globals_pkg::*;
#(
    parameter int DEPTH              = OUTSTANDING_FIFO_DEPTH,
    parameter int ID_WIDTH           = AXI4_ID_WIDTH,
    parameter int ADDR_WIDTH         = AXI4_ADDR_WIDTH,
    parameter int MAX_PER_ID         = OST_MAX_PER_ID,
    parameter int ALMOST_FULL_THRESH = 12
) (
    input  wire logic                    aclk,
    input  wire logic                    areset,
    axi4_outstanding_id_tracker_if.slave bus
);
    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int IDC_W   = $clog2(MAX_PER_ID+1);

    // Collapsing queue: slot 0 is the oldest, occupied slots are 0..count-1.
    axi4_ost_entry_s       entries_q [DEPTH];
    axi4_ost_entry_s       entries_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDC_W-1:0]      id_cnt_q [NUM_IDS];
    logic [IDC_W-1:0]      id_cnt_d [NUM_IDS];
    logic [NUM_IDS-1:0]    id_busy_q, id_busy_d;
    logic                  empty_q, full_q, almost_full_q;

    logic                  rsp_valid_q, rsp_hit_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic [7:0]            rsp_len_q;
    logic [2:0]            rsp_size_q;
    logic [1:0]            rsp_burst_q;

    logic [DEPTH-1:0]      w_match;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_pop_hit;
    logic                  w_push_ready;
    logic                  w_push_acc;
    logic [CNT_W-1:0]      w_wr_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = valid_q[i] &&
                         (entries_q[i].id == AXI4_ID_WIDTH'(bus.pop_id));
        end
    end

    axi4_ost_first_match #(.DEPTH(DEPTH)) u_first_match (
        .match_i (w_match),
        .hit_o   (w_hit),
        .idx_o   (w_idx)
    );

    assign w_pop_hit    = bus.pop_req && w_hit;
    // Registered state only: a same-cycle pop never frees room for a push.
    assign w_push_ready = !full_q && (id_cnt_q[bus.push_id] < IDC_W'(MAX_PER_ID));
    assign w_push_acc   = bus.push_valid && w_push_ready;
    // With a concurrent retire the queue collapses first, so the new record
    // lands one slot lower.
    assign w_wr_idx     = w_pop_hit ? (count_q - CNT_W'(1)) : count_q;

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        if (w_pop_hit) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (i >= int'(w_idx)) begin
                    entries_d[i] = entries_q[i+1];
                    valid_d[i]   = valid_q[i+1];
                end
            end
            entries_d[DEPTH-1] = '0;
            valid_d[DEPTH-1]   = 1'b0;
        end
        if (w_push_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == w_wr_idx) begin
                    entries_d[i].id    = AXI4_ID_WIDTH'(bus.push_id);
                    entries_d[i].addr  = AXI4_ADDR_WIDTH'(bus.push_addr);
                    entries_d[i].len   = bus.push_len;
                    entries_d[i].size  = bus.push_size;
                    entries_d[i].burst = bus.push_burst;
                    valid_d[i]         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(w_push_acc) - CNT_W'(w_pop_hit);
        for (int i = 0; i < NUM_IDS; i++) begin
            id_cnt_d[i] = id_cnt_q[i]
                        + IDC_W'(w_push_acc && (bus.push_id == ID_WIDTH'(i)))
                        - IDC_W'(w_pop_hit  && (bus.pop_id  == ID_WIDTH'(i)));
            id_busy_d[i] = (id_cnt_d[i] != '0);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            for (int i = 0; i < NUM_IDS; i++) begin
                id_cnt_q[i] <= '0;
            end
            valid_q       <= '0;
            count_q       <= '0;
            id_busy_q     <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_len_q     <= '0;
            rsp_size_q    <= '0;
            rsp_burst_q   <= '0;
        end else begin
            entries_q     <= entries_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
            id_cnt_q      <= id_cnt_d;
            id_busy_q     <= id_busy_d;
            empty_q       <= (count_d == '0);
            full_q        <= (count_d == CNT_W'(DEPTH));
            almost_full_q <= (count_d >= CNT_W'(ALMOST_FULL_THRESH));
            rsp_valid_q   <= bus.pop_req;
            rsp_hit_q     <= w_pop_hit;
            if (w_pop_hit) begin
                rsp_addr_q  <= ADDR_WIDTH'(entries_q[w_idx].addr);
                rsp_len_q   <= entries_q[w_idx].len;
                rsp_size_q  <= entries_q[w_idx].size;
                rsp_burst_q <= entries_q[w_idx].burst;
            end else begin
                rsp_addr_q  <= '0;
                rsp_len_q   <= '0;
                rsp_size_q  <= '0;
                rsp_burst_q <= '0;
            end
        end
    end

    assign bus.push_ready  = w_push_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_len     = rsp_len_q;
    assign bus.rsp_size    = rsp_size_q;
    assign bus.rsp_burst   = rsp_burst_q;
    assign bus.count       = count_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.id_busy     = id_busy_q;

endmodule : axi4_outstanding_id_tracker
`default_nettype wire

// File: tb/tb_axi4_outstanding_id_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_outstanding_id_tracker
//  Description : Self-checking bench for axi4_outstanding_id_tracker
//                (DEPTH=16, ID_WIDTH=4, MAX_PER_ID=2, ALMOST_FULL_THRESH=12).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_outstanding_id_tracker;
    localparam int DEPTH = 16;
    localparam int MAXPI = 2;
    localparam int THR   = 12;

    logic aclk   = 1'b0;
    logic areset = 1'b0;
    bit   chk_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 aclk = ~aclk;

    axi4_outstanding_id_tracker_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();

    axi4_outstanding_id_tracker #(
        .DEPTH(DEPTH), .ID_WIDTH(4), .ADDR_WIDTH(32),
        .MAX_PER_ID(MAXPI), .ALMOST_FULL_THRESH(THR)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.slave)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: ordered list of outstanding records
    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ent_t;

    ent_t mq[$];
    bit   e_rv, e_hit;
    ent_t e_rsp;

    function automatic int id_count(input logic [3:0] id);
        int n = 0;
        foreach (mq[j]) if (mq[j].id == id) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && (id_count(bus.push_id) < MAXPI);
    endfunction

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            mq.delete();
            e_rv  = 1'b0;
            e_hit = 1'b0;
            e_rsp = '{default: 0};
        end else begin
            bit   acc;
            int   k;
            ent_t n;
            acc   = bus.push_valid && m_ready();
            e_rv  = bus.pop_req;
            e_hit = 1'b0;
            e_rsp = '{default: 0};
            if (bus.pop_req) begin
                k = -1;
                foreach (mq[j]) if (k < 0 && mq[j].id == bus.pop_id) k = j;
                if (k >= 0) begin
                    e_hit = 1'b1;
                    e_rsp = mq[k];
                    mq.delete(k);
                end
            end
            if (acc) begin
                n.id    = bus.push_id;
                n.addr  = bus.push_addr;
                n.len   = bus.push_len;
                n.size  = bus.push_size;
                n.burst = bus.push_burst;
                mq.push_back(n);
            end
        end
    end

    // ---------------- per-cycle compare against the model
    always @(negedge aclk) begin
        if (!areset && chk_en) begin
            logic [15:0] busy;
            busy = '0;
            foreach (mq[j]) busy[mq[j].id] = 1'b1;
            chk("count",       bus.count,       mq.size());
            chk("empty",       bus.empty,       mq.size() == 0);
            chk("full",        bus.full,        mq.size() == DEPTH);
            chk("almost_full", bus.almost_full, mq.size() >= THR);
            chk("id_busy",     bus.id_busy,     busy);
            chk("push_ready",  bus.push_ready,  m_ready());
            chk("rsp_valid",   bus.rsp_valid,   e_rv);
            chk("rsp_hit",     bus.rsp_hit,     e_hit);
            chk("rsp_addr",    bus.rsp_addr,    e_rsp.addr);
            chk("rsp_len",     bus.rsp_len,     e_rsp.len);
            chk("rsp_size",    bus.rsp_size,    e_rsp.size);
            chk("rsp_burst",   bus.rsp_burst,   e_rsp.burst);
        end
    end

    // ---------------- stimulus
    task automatic cyc(input bit pv, input logic [3:0] pid, input logic [31:0] pa,
                       input bit pr, input logic [3:0] qid);
        bus.push_valid = pv;
        bus.push_id    = pid;
        bus.push_addr  = pa;
        bus.push_len   = pa[11:4];
        bus.push_size  = pa[2:0] ^ 3'd5;
        bus.push_burst = pid[1:0];
        bus.pop_req    = pr;
        bus.pop_id     = qid;
        @(posedge aclk);
        #1;
        bus.push_valid = 1'b0;
        bus.pop_req    = 1'b0;
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] addr);
        cyc(1'b1, id, addr, 1'b0, 4'd0);
    endtask

    task automatic pop(input logic [3:0] id);
        cyc(1'b0, 4'd0, 32'd0, 1'b1, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_valid = 1'b0; bus.push_id = '0; bus.push_addr = '0;
        bus.push_len = '0; bus.push_size = '0; bus.push_burst = '0;
        bus.pop_req = 1'b0; bus.pop_id = '0;

        #1 areset = 1'b1;
        #1;
        chk("rst_count",     bus.count, 0);
        chk("rst_empty",     bus.empty, 1);
        chk("rst_full",      bus.full, 0);
        chk("rst_af",        bus.almost_full, 0);
        chk("rst_busy",      bus.id_busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_addr",  bus.rsp_addr, 0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        chk_en = 1'b1;

        // Per-id in-order retire.
        push(4'd3, 32'h100); push(4'd5, 32'h200); push(4'd3, 32'h300);
        chk("t1_count3", bus.count, 3);
        pop(4'd3);
        chk("t1_hit", bus.rsp_hit, 1);
        chk("t1_addr_a", bus.rsp_addr, 32'h100);
        chk("t1_count2", bus.count, 2);
        pop(4'd3);
        chk("t1_addr_b", bus.rsp_addr, 32'h300);
        // Back-to-back pops: second misses.
        pop(4'd5);
        chk("t1_addr_c", bus.rsp_addr, 32'h200);
        pop(4'd5);
        chk("t1_miss_valid", bus.rsp_valid, 1);
        chk("t1_miss_hit", bus.rsp_hit, 0);

        // Pop while empty.
        pop(4'd9);
        chk("t5_valid", bus.rsp_valid, 1);
        chk("t5_hit", bus.rsp_hit, 0);
        chk("t5_addr", bus.rsp_addr, 0);
        chk("t5_count", bus.count, 0);

        // Fill all slots.
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 32'h1000 + 32'(i) * 32'h10);
            if (i == 10) chk("t2_af_11", bus.almost_full, 0);
            if (i == 11) chk("t2_af_12", bus.almost_full, 1);
        end
        chk("t2_full", bus.full, 1);
        chk("t2_ready", bus.push_ready, 0);
        push(4'd0, 32'hDEAD);
        chk("t2_count16", bus.count, 16);
        // Push + pop while full: only the pop takes effect.
        cyc(1'b1, 4'd4, 32'hBEEF, 1'b1, 4'd0);
        chk("t2_fp_addr", bus.rsp_addr, 32'h1000);
        chk("t2_fp_count", bus.count, 15);
        for (int i = 1; i < 16; i++) pop(4'(i));
        chk("t2_drained", bus.empty, 1);

        // Per-id cap.
        push(4'd7, 32'h700); push(4'd7, 32'h710);
        bus.push_id = 4'd7;
        #1 chk("t3_ready7", bus.push_ready, 0);
        push(4'd7, 32'h720);
        chk("t3_count2", bus.count, 2);
        push(4'd8, 32'h800);
        chk("t3_count3", bus.count, 3);
        pop(4'd7); chk("t3_a", bus.rsp_addr, 32'h700);
        pop(4'd7); chk("t3_b", bus.rsp_addr, 32'h710);
        pop(4'd8);

        // Simultaneous push and pop-hit.
        push(4'd3, 32'hA00); push(4'd1, 32'hB00); push(4'd3, 32'hC00); push(4'd6, 32'hD00);
        cyc(1'b1, 4'd2, 32'hE00, 1'b1, 4'd1);
        chk("t4_addr", bus.rsp_addr, 32'hB00);
        chk("t4_count", bus.count, 4);
        pop(4'd3); chk("t4_o1", bus.rsp_addr, 32'hA00);
        pop(4'd3); chk("t4_o2", bus.rsp_addr, 32'hC00);
        pop(4'd6); chk("t4_o3", bus.rsp_addr, 32'hD00);
        pop(4'd2); chk("t4_o4", bus.rsp_addr, 32'hE00);

        // Reset mid-operation.
        for (int i = 0; i < 6; i++) push(4'(i), 32'h2000 + 32'(i));
        chk("t6_count6", bus.count, 6);
        bus.pop_req = 1'b1;
        bus.pop_id  = 4'd2;
        #2 areset = 1'b1;
        #1;
        chk("t6_count", bus.count, 0);
        chk("t6_empty", bus.empty, 1);
        chk("t6_busy", bus.id_busy, 0);
        chk("t6_rv", bus.rsp_valid, 0);
        chk("t6_ready", bus.push_ready, 1);
        bus.pop_req = 1'b0;
        @(posedge aclk);
        #1 areset = 1'b0;
        repeat (3) begin
            @(posedge aclk);
            #1 chk("t6_no_rsp", bus.rsp_valid, 0);
        end

        repeat (2) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_axi4_outstanding_id_tracker
`default_nettype wire

// File: doc/axi4_outstanding_id_tracker.md
Name: axi4_outstanding_id_tracker

Overview:
Parametrised outstanding-transaction store for the AXI4 BFM, replacing the plain fixed-depth in-order outstanding FIFO. It records address-phase attributes (id, addr, len, size, burst) on each AW/AR handshake. On response (B or R-last), it retires the oldest entry whose id matches. Completion is out-of-order across ids and strictly in-order within one id. One instance sits in each of the master and slave write and read paths.

Parameters:
DEPTH, 16, total entries (OUTSTANDING_FIFO_DEPTH), ≥2
ID_WIDTH, 4, id bits; NUM_IDS = 2**ID_WIDTH
ADDR_WIDTH, 32, address bits
MAX_PER_ID, 16, max outstanding entries per id, 1..DEPTH
ALMOST_FULL_THRESH, 12, almost_full asserts when count ≥ this value
CNT_W, $clog2(DEPTH+1), derived, not overridable

Ports:
aclk  in  1  clock, rising edge
areset  in  1  asynchronous, active-high reset
push_valid  in  1  address-phase record offered
push_ready  out  1  tracker can accept the record
push_id  in  ID_WIDTH  transaction id
push_addr  in  ADDR_WIDTH  start address
push_len  in  8  burst length (awlen/arlen)
push_size  in  3  transfer size
push_burst  in  2  burst type
pop_req  in  1  retire request (one-cycle pulse per response)
pop_id  in  ID_WIDTH  id of the response
rsp_valid  out  1  lookup result valid
rsp_hit  out  1  a matching entry was found and removed
rsp_addr  out  ADDR_WIDTH  retired entry address
rsp_len  out  8  retired entry length
rsp_size  out  3  retired entry size
rsp_burst  out  2  retired entry burst
count  out  CNT_W  occupied entries
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count ≥ ALMOST_FULL_THRESH
id_busy  out  NUM_IDS  bit i set when id i has ≥1 entry

Behaviour:
- Reset (async assert, sync release) clears all entries and valid bits. count=0, empty=1, full=0, almost_full=0, id_busy=0, rsp_valid=0, rsp_hit=0, all rsp_* fields =0. A reset during an operation discards all state, including any pending response.
- Storage is a collapsing queue: index 0 is the oldest entry; occupied entries are always 0..count-1.
- There is a per-id counter array (width $clog2(MAX_PER_ID+1)).
- push_ready = !full && id_cnt[push_id] < MAX_PER_ID. It is computed combinationally from registered state only. There is no bypass through a same-cycle pop.
- Push accepted on push_valid && push_ready. The record is written at count, or at count-1 if a pop hits in the same cycle. If push_valid is high while push_ready is low, the push is ignored and state is unchanged.
- Pop lookup uses the pre-edge state. A priority encoder finds the lowest index k with valid && id==pop_id.
  - Hit: entries k+1..count-1 shift down by one and the vacated top slot is cleared.
  - A same-cycle push with the same id is not visible to that lookup.
- Response latency is 1 cycle. On the edge after pop_req, rsp_valid=1 for exactly one cycle.
  - rsp_hit and rsp_* carry the retired entry.
  - On a miss (including pop_req while empty), rsp_hit=0, all rsp_* =0, and state is unchanged.
- pop_req on consecutive cycles is legal; each request produces its own rsp_valid cycle.
- count next = count + push_accept − pop_hit, so a simultaneous push and pop-hit leaves count unchanged.
- Per-id counters follow the same rule. id_busy[i] = (id_cnt[i]!=0).
- count, empty, full, almost_full and id_busy are registered and reflect the post-edge state.
- A push and a pop-hit on the same cycle while full is legal. push_ready is already 0 while full, so only the pop takes effect.

Decomposition:
- axi4_globals_pkg gains:
  - typedef struct axi4_ost_entry_s {id, addr, len, size, burst}.
  - OUTSTANDING_FIFO_DEPTH as the default DEPTH.
  - OST_MAX_PER_ID constant.
- Sub-module axi4_ost_first_match: combinational find-first-set over a DEPTH-wide match vector. Outputs are hit and a $clog2(DEPTH)-bit index.

Test Plan:
- Push ids 3,5,3 (addrs 0x100,0x200,0x300); pop_id=3 → next cycle rsp_hit=1, rsp_addr=0x100, count=2; pop_id=3 again → rsp_addr=0x300.
- Fill 16 entries with id 0..15 → full=1, push_ready=0, almost_full from count 12; an extra push is ignored and count stays 16.
- MAX_PER_ID=2: push id 7 twice, then a third push with id 7 → push_ready=0; a push with id 8 is accepted.
- With count=4, same-cycle push(id 2) and pop(id 1, present) → count stays 4; the new entry sits at index 3 and the order of the remaining entries is preserved.
- pop_req with pop_id=9 while empty → rsp_valid=1, rsp_hit=0, rsp_addr=0, count=0.
- Assert areset mid-burst with count=6 and pop_req high → all outputs reach their reset values immediately; no rsp_valid after release.
